muxn_skid: RTL and testbench

MUXN_SKID -- requirements
Module: muxn_skid

---
 rtl/muxn_skid.sv | 107 ++++++++++
 tb/tb_muxn_skid.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_skid.sv
// rtl/muxn_skid.sv - N-way select feeding a 2-entry registered skid buffer
module muxn_skid #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [SELW-1:0]      s,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  input  logic                 flush
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] head_nx;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] skid_nx;
  logic             ready_q;
  logic [WIDTH-1:0] sel_data;
  logic             acc;
  logic             dlv;

  // Pick d[s]; a select with no matching input leaves the result at zero
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (s == SELW'(i)) sel_data = d[i*WIDTH +: WIDTH];
    end
  end

  assign acc = in_valid & ready_q;
  assign dlv = (state != EMPTY) & out_ready;

  // Next occupancy and entry contents; head is zeroed whenever the buffer drains
  always_comb begin
    state_nx = state;
    head_nx  = head;
    skid_nx  = skid;
    case (state)
      EMPTY: begin
        if (acc) begin
          state_nx = ONE;
          head_nx  = sel_data;
        end
      end
      ONE: begin
        if (acc && !dlv) begin
          state_nx = FULL;
          skid_nx  = sel_data;
        end else if (dlv && !acc) begin
          state_nx = EMPTY;
          head_nx  = '0;
        end else if (acc && dlv) begin
          head_nx  = sel_data;
        end
      end
      FULL: begin
        if (dlv) begin
          state_nx = ONE;
          head_nx  = skid;
          skid_nx  = '0;
        end
      end
      default: begin
        state_nx = EMPTY;
        head_nx  = '0;
        skid_nx  = '0;
      end
    endcase
  end

  // State register; reset beats flush, flush beats any transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b1;
    end else if (flush) begin
      state   <= EMPTY;
      head    <= '0;
      skid    <= '0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      head    <= head_nx;
      skid    <= skid_nx;
      ready_q <= (state_nx != FULL);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = head;

endmodule

// File: tb/tb_muxn_skid.sv
// tb/tb_muxn_skid.sv - self-checking bench for muxn_skid (N=4 and N=3 instances)
module tb_muxn_skid;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] d4;
  logic [95:0]  d3;
  logic [1:0]   s;
  logic         in_valid;
  logic         out_ready;
  logic         flush;
  logic         in_ready4, out_valid4;
  logic [31:0]  out_data4;
  logic         in_ready3, out_valid3;
  logic [31:0]  out_data3;

  int tests_run    = 0;
  int tests_failed = 0;

  assign d3 = d4[95:0];

  always #5 clk = ~clk;

  muxn_skid #(.WIDTH(32), .N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .d(d4), .s(s), .in_valid(in_valid),
    .in_ready(in_ready4), .out_data(out_data4), .out_valid(out_valid4),
    .out_ready(out_ready), .flush(flush)
  );

  muxn_skid #(.WIDTH(32), .N(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .d(d3), .s(s), .in_valid(in_valid),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready), .flush(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] v);
    d4[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; s = 2'd0; d4 = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; s = 2'd1;
    d4 = {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};
    in_valid = 1'b1;
    tick();
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    tests_run++;
    if (in_ready4 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %0b want 1", in_ready4); end
    tests_run++;
    if (out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %0b want 0", out_valid4); end
    tests_run++;
    if (out_data4 !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data4); end
  endtask

  task automatic test_basic();
    logic [31:0] w [4];
    do_reset();
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33; w[3] = 32'h44;
    d4 = {w[3], w[2], w[1], w[0]};
    s = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_data4 !== 32'h33 || out_valid4 !== 1'b1) begin
      tests_failed++; $display("FAIL basic_first got data=%h valid=%0b want 33/1", out_data4, out_valid4);
    end
    for (int i = 0; i < 4; i++) begin
      s = 2'(i);
      tick();
      tests_run++;
      if (out_data4 !== w[i] || out_valid4 !== 1'b1 || in_ready4 !== 1'b1) begin
        tests_failed++;
        $display("FAIL basic_stream[%0d] got data=%h valid=%0b ready=%0b want %h/1/1", i, out_data4, out_valid4, in_ready4, w[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    tests_run++;
    if (out_valid4 !== 1'b0 || out_data4 !== 32'h0) begin
      tests_failed++; $display("FAIL basic_drain got data=%h valid=%0b want 0/0", out_data4, out_valid4);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; s = 2'd0; in_valid = 1'b1;
    set_word(0, 32'hA);
    tick();
    set_word(0, 32'hB);
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (in_ready4 !== 1'b0 || out_data4 !== 32'hA || out_valid4 !== 1'b1) begin
      tests_failed++; $display("FAIL bp_full got ready=%0b data=%h valid=%0b want 0/a/1", in_ready4, out_data4, out_valid4);
    end
    tick();
    tests_run++;
    if (out_data4 !== 32'hA || in_ready4 !== 1'b0) begin
      tests_failed++; $display("FAIL bp_hold got data=%h ready=%0b want a/0", out_data4, in_ready4);
    end
    out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_data4 !== 32'hB || out_valid4 !== 1'b1 || in_ready4 !== 1'b1) begin
      tests_failed++; $display("FAIL bp_second got data=%h valid=%0b ready=%0b want b/1/1", out_data4, out_valid4, in_ready4);
    end
    tick();
    tests_run++;
    if (out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL bp_empty got valid=%0b want 0", out_valid4); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    d4 = {32'h99, 32'h77, 32'h66, 32'h55};
    s = 2'd3; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_valid3 !== 1'b1 || out_data3 !== 32'h0 || in_ready3 !== 1'b1) begin
      tests_failed++; $display("FAIL oor_n3 got valid=%0b data=%h ready=%0b want 1/0/1", out_valid3, out_data3, in_ready3);
    end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b0; s = 2'd1; in_valid = 1'b1;
    set_word(1, 32'h1);
    tick();
    set_word(1, 32'h2);
    tick();
    tests_run++;
    if (in_ready4 !== 1'b0) begin tests_failed++; $display("FAIL flush_prefull got ready=%0b want 0", in_ready4); end
    set_word(1, 32'hC); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tests_run++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1 || out_data4 !== 32'h0) begin
      tests_failed++; $display("FAIL flush_full got valid=%0b ready=%0b data=%h want 0/1/0", out_valid4, in_ready4, out_data4);
    end
    in_valid = 1'b1; set_word(1, 32'h3);
    tick();
    set_word(1, 32'hC); flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tests_run++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin
      tests_failed++; $display("FAIL flush_one got valid=%0b ready=%0b want 0/1", out_valid4, in_ready4);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if (out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL flush_leak[%0d] got valid=%0b data=%h want 0", i, out_valid4, out_data4); end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s = 2'd0; set_word(0, 32'h55); in_valid = 1'b1; out_ready = 1'b0;
    tick();
    tests_run++;
    if (out_data4 !== 32'h55 || out_valid4 !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_pre got data=%h valid=%0b want 55/1", out_data4, out_valid4);
    end
    set_word(0, 32'h66); rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid = 1'b0;
    tests_run++;
    if (out_valid4 !== 1'b0 || out_data4 !== 32'h0 || in_ready4 !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_post got valid=%0b data=%h ready=%0b want 0/0/1", out_valid4, out_data4, in_ready4);
    end
    set_word(0, 32'h77); in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (out_data4 !== 32'h77 || out_valid4 !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_next got data=%h valid=%0b want 77/1", out_data4, out_valid4);
    end
    tick();
    tests_run++;
    if (out_valid4 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_drain got valid=%0b want 0", out_valid4); end
  endtask

  task automatic test_random();
    logic [31:0] q4 [$];
    logic [31:0] q3 [$];
    logic [31:0] exp4, exp3, v4, v3;
    logic        ir_a, ir_b;
    int          n4, n3;
    do_reset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) set_word(i, $urandom);
      s         = 2'($urandom_range(0, 3));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0 ? 1 : 0) ^ 1'(cyc[9]);
      flush     = ($urandom_range(0, 40) == 0);
      #1;
      ir_a = in_ready4;
      out_ready = ~out_ready;
      #1;
      ir_b = in_ready4;
      out_ready = ~out_ready;
      #1;
      tests_run++;
      if (ir_a !== ir_b) begin tests_failed++; $display("FAIL rand_comb_path cyc=%0d got %0b vs %0b want equal", cyc, ir_a, ir_b); end

      n4 = q4.size(); n3 = q3.size();
      exp4 = (n4 > 0) ? q4[0] : 32'h0;
      exp3 = (n3 > 0) ? q3[0] : 32'h0;
      tests_run++;
      if (out_valid4 !== (n4 > 0) || in_ready4 !== (n4 < 2) || out_data4 !== exp4) begin
        tests_failed++;
        $display("FAIL rand_n4 cyc=%0d got v=%0b r=%0b d=%h want v=%0b r=%0b d=%h", cyc, out_valid4, in_ready4, out_data4, n4 > 0, n4 < 2, exp4);
      end
      tests_run++;
      if (out_valid3 !== (n3 > 0) || in_ready3 !== (n3 < 2) || out_data3 !== exp3) begin
        tests_failed++;
        $display("FAIL rand_n3 cyc=%0d got v=%0b r=%0b d=%h want v=%0b r=%0b d=%h", cyc, out_valid3, in_ready3, out_data3, n3 > 0, n3 < 2, exp3);
      end

      v4 = d4[int'(s)*32 +: 32];
      v3 = (s < 2'd3) ? v4 : 32'h0;
      if (flush) begin
        q4.delete();
        q3.delete();
      end else begin
        if (n4 > 0 && out_ready) void'(q4.pop_front());
        if (in_valid && n4 < 2) q4.push_back(v4);
        if (n3 > 0 && out_ready) void'(q3.pop_front());
        if (in_valid && n3 < 2) q3.push_back(v3);
      end
      tick();
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; d4 = '0; s = 2'd0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_out_of_range();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
